// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and helpers for the unified-memory arbiter.
//                - req_id_t / mem_cmd_t : requester id and memory command for
//                  the default configuration (2 requesters, 32-bit address
//                  and data).
//                - id_width()           : requester-id width for any NUM_REQ.
//                  It never returns less than 1 bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_DEF_NUM_REQ = 2;
    localparam int c_DEF_ADDR_W  = 32;
    localparam int c_DEF_DATA_W  = 32;

    typedef logic [$clog2(c_DEF_NUM_REQ)-1:0] req_id_t;

    typedef struct packed {
        logic                        we;
        logic [c_DEF_ADDR_W-1:0]     addr;
        logic [c_DEF_DATA_W-1:0]     wdata;
        logic [c_DEF_DATA_W/8-1:0]   be;
    } mem_cmd_t;

    // Width of a requester id. Never zero, so that a single-bit id still
    // exists when NUM_REQ is small.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter with a last-grant register.
//                - Search order : starts at last_grant+1 and wraps around.
//                - Reset value  : last_grant = NUM_REQ-1, so requester 0 wins
//                  the first contention after reset.
//                - Update rule  : last_grant changes only when a grant issues.
//                - No grant is issued while reset is held.
//                - Optional lock (macro MEM_ARB_LOCK_EN): while the most
//                  recent grant holder keeps i_lock asserted, only that holder
//                  can be granted.
//  Ports       :
//                clk           in   1          clock
//                rst_n         in   1          asynchronous reset, active low
//                i_valid       in   NUM_REQ    request vector
//                i_lock        in   NUM_REQ    lock request (MEM_ARB_LOCK_EN only)
//                o_grant       out  NUM_REQ    one-hot grant, or zero
//                o_grant_valid out  1          a grant is issued this cycle
//                o_grant_id    out  ID_W       index of the granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [NUM_REQ-1:0] i_lock,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_grant_valid,
    output logic [ID_W-1:0]    o_grant_id
);

    logic [ID_W-1:0]    r_last;
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_req_hi;
    logic               w_found;
    logic [ID_W-1:0]    w_id;

`ifdef MEM_ARB_LOCK_EN
    // Set once any grant has issued since reset. Right after reset there is
    // no previous holder, so nobody can be holding the lock.
    logic r_xfer_seen;
    logic w_lock_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_seen <= 1'b0;
        end else if (w_found) begin
            r_xfer_seen <= 1'b1;
        end
    end

    assign w_lock_active = r_xfer_seen & i_lock[r_last];
    assign w_req = w_lock_active ? (i_valid & (NUM_REQ'(1) << r_last) & {NUM_REQ{rst_n}})
                                 : (i_valid & {NUM_REQ{rst_n}});
`else
    logic w_unused_lock;
    assign w_unused_lock = ^i_lock;
    assign w_req = i_valid & {NUM_REQ{rst_n}};
`endif

    // Round-robin search, done in two halves.
    // - First half  : the lowest requester above last_grant.
    // - Second half : if there is none, the lowest requester overall.
    // This matches a wrapping search that starts at last_grant+1.
    always_comb begin
        w_req_hi = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_req_hi[j] = w_req[j] && (j > int'(r_last));
        end
    end

    always_comb begin
        w_found = |w_req;
        w_id    = '0;
        if (|w_req_hi) begin
            for (int j = NUM_REQ - 1; j >= 0; j--) begin
                if (w_req_hi[j]) begin
                    w_id = ID_W'(j);
                end
            end
        end else begin
            for (int j = NUM_REQ - 1; j >= 0; j--) begin
                if (w_req[j]) begin
                    w_id = ID_W'(j);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= ID_W'(NUM_REQ - 1);
        end else if (w_found) begin
            r_last <= w_id;
        end
    end

    assign o_grant       = w_found ? (NUM_REQ'(1) << w_id) : '0;
    assign o_grant_valid = w_found;
    assign o_grant_id    = w_id;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port memory between NUM_REQ requesters.
//                - Requester roles : 0 = CPU, 1 = GPU scanout, the rest DMA.
//                - Arbitration     : round robin, at most one access issued
//                  per cycle.
//                - Read responses  : returned to the issuing requester
//                  MEM_LATENCY cycles after the access is issued.
//                - Optional feature: macro MEM_ARB_LOCK_EN enables the
//                  req_lock_i hold-grant behaviour. Without it, req_lock_i
//                  is ignored.
//  Ports       :
//                clk_i        in   1                    clock
//                reset_ni     in   1                    async reset, active low
//                req_valid_i  in   NUM_REQ              request pending
//                req_ready_o  out  NUM_REQ              request accepted (one-hot/0)
//                req_we_i     in   NUM_REQ              1 = write
//                req_addr_i   in   NUM_REQ x ADDR_W     address
//                req_wdata_i  in   NUM_REQ x DATA_W     write data
//                req_be_i     in   NUM_REQ x DATA_W/8   byte enables
//                req_lock_i   in   NUM_REQ              hold grant (MEM_ARB_LOCK_EN)
//                rsp_valid_o  out  NUM_REQ              read data valid (one-hot/0)
//                rsp_rdata_o  out  DATA_W               read data (shared)
//                mem_en_o     out  1                    memory access strobe
//                mem_we_o     out  1                    memory write
//                mem_addr_o   out  ADDR_W               memory address
//                mem_wdata_o  out  DATA_W               memory write data
//                mem_be_o     out  DATA_W/8             memory byte enables
//                mem_rdata_i  in   DATA_W               memory read data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                               clk_i,
    input  logic                               reset_ni,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ-1:0]                 req_we_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]     req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_wdata_i,
    input  logic [NUM_REQ-1:0][DATA_W/8-1:0]   req_be_i,
    input  logic [NUM_REQ-1:0]                 req_lock_i,
    output logic [NUM_REQ-1:0]                 rsp_valid_o,
    output logic [DATA_W-1:0]                  rsp_rdata_o,
    output logic                               mem_en_o,
    output logic                               mem_we_o,
    output logic [ADDR_W-1:0]                  mem_addr_o,
    output logic [DATA_W-1:0]                  mem_wdata_o,
    output logic [DATA_W/8-1:0]                mem_be_o,
    input  logic [DATA_W-1:0]                  mem_rdata_i
);

    localparam int c_ID_W = id_width(NUM_REQ);

    // Command for this instance's parameter set. The package type only
    // covers the default widths.
    typedef struct packed {
        logic                  we;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_W-1:0]     wdata;
        logic [DATA_W/8-1:0]   be;
    } cmd_t;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_grant_valid;
    logic [c_ID_W-1:0]  w_grant_id;
    cmd_t               w_cmd;

    logic [MEM_LATENCY-1:0]             r_pipe_vld;
    logic [MEM_LATENCY-1:0][c_ID_W-1:0] r_pipe_id;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (c_ID_W)
    ) u_rr_arbiter (
        .clk           (clk_i),
        .rst_n         (reset_ni),
        .i_valid       (req_valid_i),
        .i_lock        (req_lock_i),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    assign req_ready_o = w_grant;

    // Payload mux. Address and write data pass through unconditionally, so
    // their value is meaningless when no access is issued. The strobes, in
    // contrast, are forced to zero in that case.
    always_comb begin
        w_cmd.we    = w_grant_valid & req_we_i[w_grant_id];
        w_cmd.addr  = req_addr_i[w_grant_id];
        w_cmd.wdata = req_wdata_i[w_grant_id];
        w_cmd.be    = w_grant_valid ? req_be_i[w_grant_id] : '0;
    end

    assign mem_en_o    = w_grant_valid;
    assign mem_we_o    = w_cmd.we;
    assign mem_addr_o  = w_cmd.addr;
    assign mem_wdata_o = w_cmd.wdata;
    assign mem_be_o    = w_cmd.be;

    // Response routing pipeline. Each stage holds {read issued, requester id}.
    // The memory returns data in order with a fixed latency, so the last
    // stage names the owner of the current mem_rdata_i.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
        end else begin
            r_pipe_vld[0] <= w_grant_valid & ~w_cmd.we;
            r_pipe_id[0]  <= w_grant_id;
            for (int s = 1; s < MEM_LATENCY; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_id[s]  <= r_pipe_id[s-1];
            end
        end
    end

    assign rsp_valid_o = r_pipe_vld[MEM_LATENCY-1]
                       ? (NUM_REQ'(1) << r_pipe_id[MEM_LATENCY-1]) : '0;
    assign rsp_rdata_o = mem_rdata_i;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Bench for mem_arbiter.
//                - Two instances are driven with the same requests: one with
//                  MEM_LATENCY=1 and one with MEM_LATENCY=3.
//                - Each instance has its own memory model.
//                - One reference model tracks the expected grants, memory
//                  contents and outstanding reads.
//                - Build with MEM_ARB_LOCK_EN defined to exercise locking.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_we;
    logic [N-1:0]          req_lock;
    logic [N-1:0][AW-1:0]  req_addr;
    logic [N-1:0][DW-1:0]  req_wdata;
    logic [N-1:0][BW-1:0]  req_be;

    logic [N-1:0]  ready     [2];
    logic [N-1:0]  rsp_valid [2];
    logic [DW-1:0] rsp_rdata [2];
    logic          mem_en    [2];
    logic          mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic [BW-1:0] mem_be    [2];
    logic [DW-1:0] mem_rdata [2];

    mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) u_dut_l1 (
        .clk_i(clk), .reset_ni(reset_n),
        .req_valid_i(req_valid), .req_ready_o(ready[0]), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .req_lock_i(req_lock), .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]),
        .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
        .mem_wdata_o(mem_wdata[0]), .mem_be_o(mem_be[0]), .mem_rdata_i(mem_rdata[0])
    );

    mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3)) u_dut_l3 (
        .clk_i(clk), .reset_ni(reset_n),
        .req_valid_i(req_valid), .req_ready_o(ready[1]), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .req_lock_i(req_lock), .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]),
        .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
        .mem_wdata_o(mem_wdata[1]), .mem_be_o(mem_be[1]), .mem_rdata_i(mem_rdata[1])
    );

    // Power-on contents of the memory. Word 4 (address 0x10) is fixed.
    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Memory attached to each instance. A read issued in cycle t is visible
    // on mem_rdata during cycle t+LAT.
    for (genvar d = 0; d < 2; d++) begin : g_env
        localparam int LAT = (d == 0) ? 1 : 3;
        logic [DW-1:0]  mem [256];
        logic [255:0]   wr_mask = '0;
        logic [DW-1:0]  pipe [LAT];
        logic [DW-1:0]  cur;
        logic [7:0]     idx;

        always @(posedge clk) begin
            idx = mem_addr[d][9:2];
            cur = wr_mask[idx] ? mem[idx] : init_word(int'(idx));
            pipe[0] <= 32'hBAD0_BAD0;
            if (mem_en[d]) begin
                if (mem_we[d]) begin
                    for (int b = 0; b < BW; b++)
                        if (mem_be[d][b]) cur[8*b +: 8] = mem_wdata[d][8*b +: 8];
                    mem[idx]     <= cur;
                    wr_mask[idx] <= 1'b1;
                end else begin
                    pipe[0] <= cur;
                end
            end
            for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
        end
        assign mem_rdata[d] = pipe[LAT-1];
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            t;
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           rdq[$];
    logic [DW-1:0] mmem [256];
    int            last_g;
    bit            has_xfer;
    int            cyc;
    int            acc;
    int            n_vec;
    int            n_miss;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp_v);
        end
    endtask

    // One clock of checking. It runs at the falling edge and compares both
    // instances against the model, then advances the model.
    task automatic sample();
        int            win;
        int            lock_only;
        int            j;
        int            k_hit;
        logic [N-1:0]  exp_rdy;
        logic [7:0]    idx;
        logic [DW-1:0] w;
        @(negedge clk);
        if (!reset_n) begin
            rdq.delete();
            last_g   = N - 1;
            has_xfer = 1'b0;
        end
        win = -1;
        lock_only = -1;
        if (reset_n) begin
`ifdef MEM_ARB_LOCK_EN
            if (has_xfer && req_lock[last_g]) lock_only = last_g;
`endif
            for (int k = 1; k <= N; k++) begin
                j = (last_g + k) % N;
                if (win < 0 && req_valid[j] && (lock_only < 0 || lock_only == j)) win = j;
            end
        end
        exp_rdy = (win >= 0) ? (N'(1) << win) : '0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ready[dut%0d]", d), 64'(ready[d]), 64'(exp_rdy));
            chk($sformatf("mem_en[dut%0d]", d), 64'(mem_en[d]), 64'(win >= 0));
            if (win >= 0) begin
                chk($sformatf("mem_we[dut%0d]", d), 64'(mem_we[d]), 64'(req_we[win]));
                chk($sformatf("mem_addr[dut%0d]", d), 64'(mem_addr[d]), 64'(req_addr[win]));
                chk($sformatf("mem_be[dut%0d]", d), 64'(mem_be[d]), 64'(req_be[win]));
                if (req_we[win])
                    chk($sformatf("mem_wdata[dut%0d]", d), 64'(mem_wdata[d]), 64'(req_wdata[win]));
            end else begin
                chk($sformatf("idle_we[dut%0d]", d), 64'(mem_we[d]), 64'd0);
                chk($sformatf("idle_be[dut%0d]", d), 64'(mem_be[d]), 64'd0);
            end
            k_hit = -1;
            foreach (rdq[k]) if (rdq[k].t + lat(d) == cyc) k_hit = k;
            if (k_hit >= 0) begin
                chk($sformatf("rsp_valid[dut%0d]", d), 64'(rsp_valid[d]), 64'(N'(1) << rdq[k_hit].id));
                chk($sformatf("rsp_rdata[dut%0d]", d), 64'(rsp_rdata[d]), 64'(rdq[k_hit].data));
            end else begin
                chk($sformatf("rsp_valid[dut%0d]", d), 64'(rsp_valid[d]), 64'd0);
            end
        end
        acc = win;
        if (win >= 0) begin
            last_g   = win;
            has_xfer = 1'b1;
            idx = req_addr[win][9:2];
            if (req_we[win]) begin
                w = mmem[idx];
                for (int b = 0; b < BW; b++)
                    if (req_be[win][b]) w[8*b +: 8] = req_wdata[win][8*b +: 8];
                mmem[idx] = w;
            end else begin
                rdq.push_back('{t: cyc, id: win, data: mmem[idx]});
            end
        end
        while (rdq.size() > 0 && rdq[0].t + 3 < cyc) void'(rdq.pop_front());
        cyc++;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        sample();
        advance();
        reset_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [BW-1:0] be);
        req_we[i]    = we;
        req_addr[i]  = a;
        req_wdata[i] = wd;
        req_be[i]    = be;
    endtask

    task automatic drive_random();
        logic [AW-1:0] a;
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || acc == i) begin
                req_valid[i] = ($urandom_range(0, 99) < 60);
                a = $urandom;
                a = (a & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2);
                set_req(i, 1'($urandom_range(0, 1)), a, $urandom, BW'($urandom));
            end
            req_lock[i] = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        n_vec = 0; n_miss = 0; cyc = 0; acc = -1;
        last_g = N - 1; has_xfer = 1'b0;
        for (int i = 0; i < 256; i++) mmem[i] = init_word(i);
        req_valid = '0; req_we = '0; req_lock = '0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        advance();
        for (int i = 0; i < 3; i++) begin sample(); advance(); end
        reset_n = 1'b1;

        // 1: single read of 0x10 returns DEADBEEF one cycle later
        req_valid = 2'b01; set_req(0, 1'b0, 32'h10, 32'h0, 4'hF);
        sample(); chk("t1_ready", 64'(ready[0]), 64'h1); advance();
        req_valid = 2'b00;
        sample();
        chk("t1_rsp_valid", 64'(rsp_valid[0]), 64'h1);
        chk("t1_rdata", 64'(rsp_rdata[0]), 64'hDEADBEEF);
        advance();

        // 2: continuous contention alternates 0,1,0,1 starting at 0
        pulse_reset();
        req_valid = 2'b11;
        set_req(0, 1'b0, 32'h20, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h24, 32'h0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            sample();
            chk("t2_ready", 64'(ready[0]), (i % 2 == 0) ? 64'h1 : 64'h2);
            chk("t2_mem_en", 64'(mem_en[0]), 64'h1);
            advance();
        end
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin sample(); advance(); end

        // 3: write from req1, then read of the same address by req0
        req_valid = 2'b10; set_req(1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF);
        sample(); chk("t3_wr_ready", 64'(ready[0]), 64'h2); advance();
        req_valid = 2'b01; set_req(0, 1'b0, 32'h40, 32'h0, 4'hF);
        sample(); chk("t3_no_wr_rsp", 64'(rsp_valid[0]), 64'h0); advance();
        req_valid = 2'b00;
        sample();
        chk("t3_rsp_valid", 64'(rsp_valid[0]), 64'h1);
        chk("t3_rdata", 64'(rsp_rdata[0]), 64'hA5A5A5A5);
        advance();

        // 4: latency 3, reads 0,1,0 on consecutive cycles
        req_valid = 2'b01; set_req(0, 1'b0, 32'h08, 32'h0, 4'hF);
        sample(); advance();
        req_valid = 2'b10; set_req(1, 1'b0, 32'h0C, 32'h0, 4'hF);
        sample(); advance();
        req_valid = 2'b01; set_req(0, 1'b0, 32'h14, 32'h0, 4'hF);
        sample(); advance();
        req_valid = 2'b00;
        sample(); chk("t4_rsp_a", 64'(rsp_valid[1]), 64'h1); advance();
        sample(); chk("t4_rsp_b", 64'(rsp_valid[1]), 64'h2); advance();
        sample(); chk("t4_rsp_c", 64'(rsp_valid[1]), 64'h1); advance();

        // 5: reset while a read is in flight
        req_valid = 2'b01; set_req(0, 1'b0, 32'h10, 32'h0, 4'hF);
        sample(); advance();
        req_valid = 2'b00;
        reset_n = 1'b0;
        sample(); advance();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("t5_no_rsp_l1", 64'(rsp_valid[0]), 64'h0);
            chk("t5_no_rsp_l3", 64'(rsp_valid[1]), 64'h0);
            advance();
        end
        req_valid = 2'b11;
        set_req(0, 1'b0, 32'h30, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h34, 32'h0, 4'hF);
        sample(); chk("t5_first_grant", 64'(ready[0]), 64'h1); advance();
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin sample(); advance(); end

`ifdef MEM_ARB_LOCK_EN
        // 6: req0 holds the lock for three accesses
        pulse_reset();
        req_valid = 2'b11; req_lock = 2'b01;
        set_req(0, 1'b0, 32'h44, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h48, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            sample(); chk("t6_locked", 64'(ready[0]), 64'h1); advance();
        end
        req_valid = 2'b10;
        sample(); chk("t6_lock_idle", 64'(ready[0]), 64'h0); advance();
        req_lock = 2'b00;
        sample(); chk("t6_release", 64'(ready[0]), 64'h2); advance();
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin sample(); advance(); end
`endif

        // random traffic with occasional reset pulses
        acc = -1;
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            reset_n = ($urandom_range(0, 199) != 0);
            sample();
            advance();
        end
        reset_n = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin sample(); advance(); end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
